// File: rtl/store_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer_pkg
//  Description : Shared sizing constants for the posted-write store buffer.
//                SB_DEPTH lives beside WORD_WIDTH so every block sizes the
//                buffer from one place.
//  Revision    : 1.0  initial release
// ============================================================================
package store_buffer_pkg;

   // Datapath width shared by the CPU and data-memory bus.
   localparam int WORD_WIDTH = 32;

   // Store buffer entries; must be a power of two and at least 2.
   localparam int SB_DEPTH   = 4;

endpackage
`default_nettype wire

// File: rtl/sb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sb_fifo
//  Description : Circular FIFO of {address, data} store entries. Holds the
//                storage, head/tail pointers and occupancy count, and exposes
//                every entry with its occupied flag for load forwarding.
//  Revision    : 1.0  initial release
// ============================================================================
module sb_fifo
   import store_buffer_pkg::*;
#(
   parameter int W     = WORD_WIDTH,
   parameter int DEPTH = SB_DEPTH,
   parameter int PW    = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic [W-1:0]              push_addr,
   input  logic [W-1:0]              push_data,
   input  logic                      pop,
   output logic [W-1:0]              head_addr,
   output logic [W-1:0]              head_data,
   output logic                      empty,
   output logic                      full,
   output logic [PW:0]               count,
   output logic [PW-1:0]             tail_ptr,
   output logic [DEPTH-1:0][W-1:0]   entry_addr,
   output logic [DEPTH-1:0][W-1:0]   entry_data,
   output logic [DEPTH-1:0]          entry_valid
);

   logic [DEPTH-1:0][W-1:0] addr_mem;
   logic [DEPTH-1:0][W-1:0] data_mem;
   logic [PW-1:0]           head;
   logic [PW-1:0]           tail;
   logic [PW:0]             cnt;

   // Entry storage: written at tail on push, no reset needed since occupancy
   // is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[tail] <= push_addr;
         data_mem[tail] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // An entry is occupied when its distance from head is below the count.
   genvar i;
   generate
      for (i = 0; i < DEPTH; i++) begin : g_valid
         assign entry_valid[i] = ({1'b0, PW'(i) - head}) < cnt;
      end
   endgenerate

   assign head_addr  = addr_mem[head];
   assign head_data  = data_mem[head];
   assign empty      = (cnt == '0);
   assign full       = (cnt == (PW+1)'(DEPTH));
   assign count      = cnt;
   assign tail_ptr   = tail;
   assign entry_addr = addr_mem;
   assign entry_data = data_mem;

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer
//  Description : Posted-write store buffer between the CPU load/store port and
//                the data-memory bus. Accepts one store per cycle, drains in
//                FIFO order, and forwards the youngest buffered store to loads.
//  Revision    : 1.0  initial release
// ============================================================================
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int W     = WORD_WIDTH,
   parameter int DEPTH = SB_DEPTH,
   parameter int PW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   // CPU side
   input  logic          store_en,
   input  logic [W-1:0]  s_addr,
   input  logic [W-1:0]  s_data,
   input  logic          load_en,
   input  logic [W-1:0]  l_addr,
   output logic [W-1:0]  l_data,
   output logic          stall,
   // Memory side
   output logic          mem_wr_valid,
   output logic [W-1:0]  mem_wr_addr,
   output logic [W-1:0]  mem_wr_data,
   input  logic          mem_wr_ready,
   output logic [W-1:0]  mem_rd_addr,
   input  logic [W-1:0]  mem_rd_data,
   // Status
   output logic          sb_empty,
   output logic [PW:0]   sb_count
);

   logic                    push;
   logic                    pop;
   logic                    empty;
   logic                    full;
   logic [PW-1:0]           tail_ptr;
   logic [DEPTH-1:0][W-1:0] entry_addr;
   logic [DEPTH-1:0][W-1:0] entry_data;
   logic [DEPTH-1:0]        entry_valid;

   // Stall depends only on the registered full flag, so a pop in the same
   // cycle still rejects the store; the CPU retries next cycle.
   assign push  = store_en && !full;
   assign stall = store_en && full;
   assign pop   = !empty && mem_wr_ready;

   sb_fifo #(
      .W     (W),
      .DEPTH (DEPTH),
      .PW    (PW)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (push),
      .push_addr   (s_addr),
      .push_data   (s_data),
      .pop         (pop),
      .head_addr   (mem_wr_addr),
      .head_data   (mem_wr_data),
      .empty       (empty),
      .full        (full),
      .count       (sb_count),
      .tail_ptr    (tail_ptr),
      .entry_addr  (entry_addr),
      .entry_data  (entry_data),
      .entry_valid (entry_valid)
   );

   assign mem_wr_valid = !empty;
   assign sb_empty     = empty;
   assign mem_rd_addr  = l_addr;

   // Youngest-match forwarding: walk backwards from the entry just behind
   // tail so the first occupied word match is the most recent store.
   always_comb begin
      logic          found;
      logic [PW-1:0] idx;
      l_data = mem_rd_data;
      found  = 1'b0;
      idx    = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = tail_ptr - PW'(k + 1);
         if (load_en && !found && entry_valid[idx] &&
             (entry_addr[idx][W-1:2] == l_addr[W-1:2])) begin
            l_data = entry_data[idx];
            found  = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_buffer
//  Description : Self-checking bench for store_buffer: directed vector table,
//                reset-mid-drain sequence and randomized traffic against a
//                queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_store_buffer;

   localparam int W     = 32;
   localparam int DEPTH = 4;
   localparam int PW    = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          store_en;
   logic [W-1:0]  s_addr;
   logic [W-1:0]  s_data;
   logic          load_en;
   logic [W-1:0]  l_addr;
   logic [W-1:0]  l_data;
   logic          stall;
   logic          mem_wr_valid;
   logic [W-1:0]  mem_wr_addr;
   logic [W-1:0]  mem_wr_data;
   logic          mem_wr_ready;
   logic [W-1:0]  mem_rd_addr;
   logic [W-1:0]  mem_rd_data;
   logic          sb_empty;
   logic [PW:0]   sb_count;

   store_buffer #(.W(W), .DEPTH(DEPTH), .PW(PW)) dut (
      .clk          (clk),
      .rst          (rst),
      .store_en     (store_en),
      .s_addr       (s_addr),
      .s_data       (s_data),
      .load_en      (load_en),
      .l_addr       (l_addr),
      .l_data       (l_data),
      .stall        (stall),
      .mem_wr_valid (mem_wr_valid),
      .mem_wr_addr  (mem_wr_addr),
      .mem_wr_data  (mem_wr_data),
      .mem_wr_ready (mem_wr_ready),
      .mem_rd_addr  (mem_rd_addr),
      .mem_rd_data  (mem_rd_data),
      .sb_empty     (sb_empty),
      .sb_count     (sb_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] addr;
      logic [W-1:0] data;
   } entry_t;

   typedef struct {
      logic         se;
      logic [W-1:0] sa;
      logic [W-1:0] sd;
      logic         le;
      logic [W-1:0] la;
      logic [W-1:0] rd;
      logic         rdy;
      int           exp_count;
      logic         exp_stall;
      logic         exp_valid;
      logic [W-1:0] exp_waddr;
      logic [W-1:0] exp_wdata;
      logic [W-1:0] exp_ldata;
   } vec_t;

   int     checks = 0;
   int     errors = 0;
   entry_t model_q[$];

   logic         prev_hold = 1'b0;
   logic [W-1:0] prev_addr = '0;
   logic [W-1:0] prev_data = '0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] model_load(input logic [W-1:0] la, input logic [W-1:0] rd);
      for (int i = model_q.size() - 1; i >= 0; i--)
         if (model_q[i].addr[W-1:2] == la[W-1:2]) return model_q[i].data;
      return rd;
   endfunction

   // Drive one cycle of inputs, then compare every output against the model
   // half a cycle later.
   task automatic apply(input logic r, input logic se, input logic [W-1:0] sa,
                        input logic [W-1:0] sd, input logic le, input logic [W-1:0] la,
                        input logic [W-1:0] rd, input logic rdy);
      rst = r; store_en = se; s_addr = sa; s_data = sd;
      load_en = le; l_addr = la; mem_rd_data = rd; mem_wr_ready = rdy;
      @(negedge clk);
      chk("m_count", W'(sb_count), W'(model_q.size()));
      chk("m_empty", W'(sb_empty), W'(model_q.size() == 0));
      chk("m_valid", W'(mem_wr_valid), W'(model_q.size() != 0));
      chk("m_stall", W'(stall), W'(se && model_q.size() == DEPTH));
      chk("m_rdaddr", mem_rd_addr, la);
      if (model_q.size() != 0) begin
         chk("m_waddr", mem_wr_addr, model_q[0].addr);
         chk("m_wdata", mem_wr_data, model_q[0].data);
      end
      if (le) chk("m_ldata", l_data, model_load(la, rd));
      if (prev_hold && mem_wr_valid) begin
         chk("hold_addr", mem_wr_addr, prev_addr);
         chk("hold_data", mem_wr_data, prev_data);
      end
   endtask

   // Clock edge: advance the reference model using pre-edge occupancy.
   task automatic tick();
      int sz;
      sz = model_q.size();
      prev_hold = mem_wr_valid && !mem_wr_ready && !rst;
      prev_addr = mem_wr_addr;
      prev_data = mem_wr_data;
      @(posedge clk);
      if (rst) begin
         model_q.delete();
      end else begin
         if (sz != 0 && mem_wr_ready) void'(model_q.pop_front());
         if (store_en && sz < DEPTH) model_q.push_back('{addr: s_addr, data: s_data});
      end
      #1;
   endtask

   vec_t vecs[$];

   function automatic vec_t mk(input logic se, input logic [W-1:0] sa, input logic [W-1:0] sd,
                               input logic le, input logic [W-1:0] la, input logic [W-1:0] rd,
                               input logic rdy, input int ec, input logic es, input logic ev,
                               input logic [W-1:0] ewa, input logic [W-1:0] ewd,
                               input logic [W-1:0] eld);
      vec_t v;
      v.se = se; v.sa = sa; v.sd = sd; v.le = le; v.la = la; v.rd = rd; v.rdy = rdy;
      v.exp_count = ec; v.exp_stall = es; v.exp_valid = ev;
      v.exp_waddr = ewa; v.exp_wdata = ewd; v.exp_ldata = eld;
      return v;
   endfunction

   initial begin
      // Directed table: inputs for the cycle and the outputs expected before
      // the following clock edge.
      //          se  s_addr  s_data        le  l_addr  rd_data  rdy cnt stl vld waddr  wdata        ldata
      vecs.push_back(mk(1, 32'h100, 32'hDEADBEEF, 0, 32'h0,  32'h0,  1, 0, 0, 0, 32'h0,  32'h0,       32'h0));
      vecs.push_back(mk(0, 32'h0,   32'h0,        0, 32'h0,  32'h0,  1, 1, 0, 1, 32'h100,32'hDEADBEEF, 32'h0));
      vecs.push_back(mk(0, 32'h0,   32'h0,        0, 32'h0,  32'h0,  0, 0, 0, 0, 32'h0,  32'h0,       32'h0));
      vecs.push_back(mk(1, 32'h0,   32'hA0,       0, 32'h0,  32'h0,  0, 0, 0, 0, 32'h0,  32'h0,       32'h0));
      vecs.push_back(mk(1, 32'h4,   32'hA4,       0, 32'h0,  32'h0,  0, 1, 0, 1, 32'h0,  32'hA0,      32'h0));
      vecs.push_back(mk(1, 32'h8,   32'hA8,       0, 32'h0,  32'h0,  0, 2, 0, 1, 32'h0,  32'hA0,      32'h0));
      vecs.push_back(mk(1, 32'hC,   32'hAC,       0, 32'h0,  32'h0,  0, 3, 0, 1, 32'h0,  32'hA0,      32'h0));
      vecs.push_back(mk(1, 32'h10,  32'hB0,       0, 32'h0,  32'h0,  0, 4, 1, 1, 32'h0,  32'hA0,      32'h0));
      vecs.push_back(mk(1, 32'h10,  32'hB0,       0, 32'h0,  32'h0,  1, 4, 1, 1, 32'h0,  32'hA0,      32'h0));
      vecs.push_back(mk(1, 32'h10,  32'hB0,       1, 32'h8,  32'h77, 0, 3, 0, 1, 32'h4,  32'hA4,      32'hA8));
      vecs.push_back(mk(0, 32'h0,   32'h0,        1, 32'h0,  32'h55, 0, 4, 0, 1, 32'h4,  32'hA4,      32'h55));
      vecs.push_back(mk(0, 32'h0,   32'h0,        1, 32'h13, 32'h0,  0, 4, 0, 1, 32'h4,  32'hA4,      32'hB0));
      vecs.push_back(mk(0, 32'h0,   32'h0,        0, 32'h0,  32'h0,  1, 4, 0, 1, 32'h4,  32'hA4,      32'h0));
      vecs.push_back(mk(0, 32'h0,   32'h0,        0, 32'h0,  32'h0,  1, 3, 0, 1, 32'h8,  32'hA8,      32'h0));
      vecs.push_back(mk(0, 32'h0,   32'h0,        0, 32'h0,  32'h0,  1, 2, 0, 1, 32'hC,  32'hAC,      32'h0));
      vecs.push_back(mk(0, 32'h0,   32'h0,        0, 32'h0,  32'h0,  1, 1, 0, 1, 32'h10, 32'hB0,      32'h0));
      vecs.push_back(mk(0, 32'h0,   32'h0,        0, 32'h0,  32'h0,  0, 0, 0, 0, 32'h0,  32'h0,       32'h0));
      vecs.push_back(mk(1, 32'h20,  32'h1,        0, 32'h0,  32'h0,  0, 0, 0, 0, 32'h0,  32'h0,       32'h0));
      vecs.push_back(mk(1, 32'h20,  32'h2,        1, 32'h20, 32'h55, 0, 1, 0, 1, 32'h20, 32'h1,       32'h1));
      vecs.push_back(mk(0, 32'h0,   32'h0,        1, 32'h20, 32'h55, 0, 2, 0, 1, 32'h20, 32'h1,       32'h2));
      vecs.push_back(mk(0, 32'h0,   32'h0,        1, 32'h24, 32'h55, 0, 2, 0, 1, 32'h20, 32'h1,       32'h55));
      vecs.push_back(mk(0, 32'h0,   32'h0,        0, 32'h0,  32'h0,  1, 2, 0, 1, 32'h20, 32'h1,       32'h0));
      vecs.push_back(mk(1, 32'h30,  32'h3,        0, 32'h0,  32'h0,  1, 1, 0, 1, 32'h20, 32'h2,       32'h0));
      vecs.push_back(mk(0, 32'h0,   32'h0,        1, 32'h20, 32'h99, 1, 1, 0, 1, 32'h30, 32'h3,       32'h99));
      vecs.push_back(mk(0, 32'h0,   32'h0,        0, 32'h0,  32'h0,  0, 0, 0, 0, 32'h0,  32'h0,       32'h0));

      // Reset held for two cycles.
      apply(1, 0, 0, 0, 0, 0, 0, 0); tick();
      apply(1, 0, 0, 0, 0, 0, 0, 0); tick();
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_valid", W'(mem_wr_valid), W'(0));
      chk("rst_empty", W'(sb_empty), W'(1));
      chk("rst_count", W'(sb_count), W'(0));
      chk("rst_stall", W'(stall), W'(0));
      tick();

      // Directed vector table.
      for (int i = 0; i < vecs.size(); i++) begin
         apply(0, vecs[i].se, vecs[i].sa, vecs[i].sd, vecs[i].le, vecs[i].la,
               vecs[i].rd, vecs[i].rdy);
         chk($sformatf("v%0d_count", i), W'(sb_count), W'(vecs[i].exp_count));
         chk($sformatf("v%0d_stall", i), W'(stall), W'(vecs[i].exp_stall));
         chk($sformatf("v%0d_valid", i), W'(mem_wr_valid), W'(vecs[i].exp_valid));
         if (vecs[i].exp_valid) begin
            chk($sformatf("v%0d_waddr", i), mem_wr_addr, vecs[i].exp_waddr);
            chk($sformatf("v%0d_wdata", i), mem_wr_data, vecs[i].exp_wdata);
         end
         if (vecs[i].le) chk($sformatf("v%0d_ldata", i), l_data, vecs[i].exp_ldata);
         tick();
      end

      // Reset mid-drain: three entries buffered, then a reset pulse.
      apply(0, 1, 32'h40, 32'h11, 0, 0, 0, 0); tick();
      apply(0, 1, 32'h44, 32'h22, 0, 0, 0, 0); tick();
      apply(0, 1, 32'h48, 32'h33, 0, 0, 0, 0); tick();
      apply(1, 0, 0, 0, 1, 32'h44, 32'hF0, 0);
      chk("pre_rst_fwd", l_data, 32'h22);
      tick();
      apply(0, 0, 0, 0, 1, 32'h44, 32'hF0, 1);
      chk("post_rst_valid", W'(mem_wr_valid), W'(0));
      chk("post_rst_count", W'(sb_count), W'(0));
      chk("post_rst_ldata", l_data, 32'hF0);
      tick();

      // Randomized traffic over a small address window so forwarding hits.
      for (int c = 0; c < 400; c++) begin
         apply(0, 1'($urandom_range(0, 1)), W'($urandom_range(0, 7) * 4),
               W'($urandom), 1'($urandom_range(0, 1)),
               W'($urandom_range(0, 7) * 4 + $urandom_range(0, 3)),
               W'($urandom), 1'($urandom_range(0, 2) == 0));
         tick();
      end

      // Final drain with ready held high.
      for (int c = 0; c < DEPTH + 2; c++) begin
         apply(0, 0, 0, 0, 0, 0, 0, 1);
         tick();
      end
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      chk("final_empty", W'(sb_empty), W'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
